// File: rtl/mvm_rf_weight_loader_pkg.sv
// mvm_rf_weight_loader_pkg: shared TUSER field layout and loader FSM states
package mvm_rf_weight_loader_pkg;
    localparam logic [1:0] RF_OP_WRITE = 2'b11;
    localparam int TUSER_ADDR_LSB = 0;
    localparam int TUSER_OP_LSB = 9;
    localparam int TUSER_RFSEL_LSB = 11;
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FIN} state_t;
endpackage

// File: rtl/mvm_axis_out_reg.sv
// mvm_axis_out_reg: single-entry AXIS holding register that can refill on the same cycle it drains
module mvm_axis_out_reg #(
    parameter int DATAW = 512,
    parameter int USERW = 75
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DATAW-1:0] in_data,
    input  logic [USERW-1:0] in_user,
    output logic             ready,
    output logic             tvalid,
    input  logic             tready,
    output logic [DATAW-1:0] tdata,
    output logic [USERW-1:0] tuser
);
    assign ready = !tvalid || tready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tuser  <= '0;
        end else if (load) begin
            tvalid <= 1'b1;
            tdata  <= in_data;
            tuser  <= in_user;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end
endmodule

// File: rtl/mvm_rf_weight_loader.sv
// mvm_rf_weight_loader: turns a flat weight stream into addressed RF-write flits for the MVM NoC port
module mvm_rf_weight_loader
    import mvm_rf_weight_loader_pkg::*;
#(
    parameter int DATAW  = 512,
    parameter int IDW    = 12,
    parameter int DESTW  = 12,
    parameter int USERW  = 75,
    parameter int NUM_RF = USERW - 11,
    parameter int ADDRW  = 9
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      START,
    input  logic [DESTW-1:0]          CFG_DEST,
    input  logic [ADDRW-1:0]          CFG_BASE_ADDR,
    input  logic [ADDRW:0]            CFG_WORDS,
    input  logic [$clog2(NUM_RF)-1:0] CFG_RF_FIRST,
    input  logic [$clog2(NUM_RF):0]   CFG_RF_COUNT,
    input  logic                      WDATA_VALID,
    output logic                      WDATA_READY,
    input  logic [DATAW-1:0]          WDATA,
    output logic                      AXIS_M_TVALID,
    input  logic                      AXIS_M_TREADY,
    output logic [DATAW-1:0]          AXIS_M_TDATA,
    output logic                      AXIS_M_TLAST,
    output logic [IDW-1:0]            AXIS_M_TID,
    output logic [USERW-1:0]          AXIS_M_TUSER,
    output logic [DESTW-1:0]          AXIS_M_TDEST,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      ERR
);
    localparam int RFW = $clog2(NUM_RF);

    state_t             state, state_next;
    logic [DESTW-1:0]   dest_q;
    logic [ADDRW-1:0]   base_q, addr;
    logic [ADDRW:0]     words_q, word_cnt;
    logic [RFW-1:0]     rf_idx, rf_last;
    logic               err_q;
    logic [RFW+1:0]     rf_end;
    logic               cfg_bad, cfg_empty, launch, out_ready, accept, word_last, job_last;
    logic [NUM_RF-1:0]  rf_sel;
    logic [USERW-1:0]   user_next;

    assign rf_end    = (RFW+2)'(CFG_RF_FIRST) + (RFW+2)'(CFG_RF_COUNT);
    assign cfg_bad   = rf_end > (RFW+2)'(NUM_RF);
    assign cfg_empty = CFG_RF_COUNT == '0 || CFG_WORDS == '0;
    assign launch    = state == IDLE && START;
    assign accept    = state == LOAD && WDATA_VALID && out_ready;
    assign word_last = word_cnt == words_q - 1'b1;
    assign job_last  = word_last && rf_idx == rf_last;
    assign rf_sel    = NUM_RF'(1) << rf_idx;

    always_comb begin
        user_next = '0;
        user_next[TUSER_ADDR_LSB +: ADDRW] = addr;
        user_next[TUSER_OP_LSB +: 2] = RF_OP_WRITE;
        user_next[TUSER_RFSEL_LSB +: NUM_RF] = rf_sel;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (START && !cfg_bad) state_next = cfg_empty ? FIN : LOAD;
            LOAD:  if (accept && job_last) state_next = DRAIN;
            DRAIN: if (out_ready) state_next = FIN;
            FIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            dest_q   <= '0;
            base_q   <= '0;
            words_q  <= '0;
            rf_last  <= '0;
            rf_idx   <= '0;
            addr     <= '0;
            word_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= launch && cfg_bad;
            if (launch) begin
                dest_q   <= CFG_DEST;
                base_q   <= CFG_BASE_ADDR;
                words_q  <= CFG_WORDS;
                rf_last  <= RFW'(rf_end - 1'b1);
                rf_idx   <= CFG_RF_FIRST;
                addr     <= CFG_BASE_ADDR;
                word_cnt <= '0;
            end else if (accept) begin
                if (word_last) begin
                    word_cnt <= '0;
                    addr     <= base_q;
                    rf_idx   <= rf_idx + 1'b1;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                    addr     <= addr + 1'b1;
                end
            end
        end
    end

    mvm_axis_out_reg #(.DATAW(DATAW), .USERW(USERW)) u_out (
        .clk     (CLK),
        .rst_n   (RST_N),
        .load    (accept),
        .in_data (WDATA),
        .in_user (user_next),
        .ready   (out_ready),
        .tvalid  (AXIS_M_TVALID),
        .tready  (AXIS_M_TREADY),
        .tdata   (AXIS_M_TDATA),
        .tuser   (AXIS_M_TUSER)
    );

    assign WDATA_READY  = state == LOAD && out_ready;
    assign AXIS_M_TLAST = AXIS_M_TVALID;
    assign AXIS_M_TID   = '0;
    assign AXIS_M_TDEST = dest_q;
    assign BUSY         = state != IDLE;
    assign DONE         = state == FIN;
    assign ERR          = err_q;
endmodule

// File: tb/tb_mvm_rf_weight_loader.sv
// tb_mvm_rf_weight_loader: randomized scoreboard bench for the RF weight loader
module tb_mvm_rf_weight_loader;
    logic         CLK, RST_N, START;
    logic [11:0]  CFG_DEST;
    logic [8:0]   CFG_BASE_ADDR;
    logic [9:0]   CFG_WORDS;
    logic [5:0]   CFG_RF_FIRST;
    logic [6:0]   CFG_RF_COUNT;
    logic         WDATA_VALID, WDATA_READY;
    logic [511:0] WDATA;
    logic         AXIS_M_TVALID, AXIS_M_TREADY, AXIS_M_TLAST;
    logic [511:0] AXIS_M_TDATA;
    logic [11:0]  AXIS_M_TID, AXIS_M_TDEST;
    logic [74:0]  AXIS_M_TUSER;
    logic         BUSY, DONE, ERR;

    mvm_rf_weight_loader dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .CFG_DEST(CFG_DEST),
        .CFG_BASE_ADDR(CFG_BASE_ADDR), .CFG_WORDS(CFG_WORDS),
        .CFG_RF_FIRST(CFG_RF_FIRST), .CFG_RF_COUNT(CFG_RF_COUNT),
        .WDATA_VALID(WDATA_VALID), .WDATA_READY(WDATA_READY), .WDATA(WDATA),
        .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(AXIS_M_TREADY),
        .AXIS_M_TDATA(AXIS_M_TDATA), .AXIS_M_TLAST(AXIS_M_TLAST),
        .AXIS_M_TID(AXIS_M_TID), .AXIS_M_TUSER(AXIS_M_TUSER),
        .AXIS_M_TDEST(AXIS_M_TDEST), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    typedef struct {
        logic [511:0] data;
        logic [74:0]  user;
        logic [11:0]  dest;
    } flit_t;

    flit_t        exp_q[$];
    logic [511:0] dq[$];
    int checks = 0, fails = 0, cyc = 0, flits = 0, done_cnt = 0, err_cnt = 0;
    int first_cyc = -1, last_cyc = -1, tready_mode = 0;
    bit busy_seen = 0, wv_full = 1, held = 0;
    logic [511:0] held_data;
    logic [74:0]  held_user;

    task automatic check(string name, logic [511:0] act, logic [511:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [511:0] rnd();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc++;

    initial begin
        AXIS_M_TREADY = 0;
        forever begin
            @(posedge CLK);
            #1;
            AXIS_M_TREADY = tready_mode == 0 ? 1'b1 : tready_mode == 1 ? ~AXIS_M_TREADY : 1'($urandom % 2);
        end
    end

    initial begin
        bit hs;
        WDATA_VALID = 0;
        WDATA = '0;
        forever begin
            @(negedge CLK);
            hs = WDATA_VALID && WDATA_READY && RST_N;
            @(posedge CLK);
            #1;
            if (hs && dq.size() > 0) void'(dq.pop_front());
            WDATA_VALID = dq.size() > 0 && (wv_full || $urandom % 4 != 0);
            WDATA = dq.size() > 0 ? dq[0] : '0;
        end
    end

    always @(negedge CLK) begin
        flit_t f;
        if (RST_N) begin
            if (BUSY) busy_seen = 1;
            if (ERR) err_cnt++;
            if (DONE) begin
                done_cnt++;
                check("done_after_all_flits", exp_q.size(), 0);
            end
            if (held) begin
                check("hold_valid", AXIS_M_TVALID, 1);
                check("hold_data", AXIS_M_TDATA, held_data);
                check("hold_user", AXIS_M_TUSER, held_user);
            end
            held = AXIS_M_TVALID && !AXIS_M_TREADY;
            if (held) begin
                check("held_wready", WDATA_READY, 0);
                held_data = AXIS_M_TDATA;
                held_user = AXIS_M_TUSER;
            end
            if (AXIS_M_TVALID && AXIS_M_TREADY) begin
                flits++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_flit", AXIS_M_TUSER, 0);
                end else begin
                    f = exp_q.pop_front();
                    check("tdata", AXIS_M_TDATA, f.data);
                    check("tuser", AXIS_M_TUSER, f.user);
                    check("tdest", AXIS_M_TDEST, f.dest);
                    check("tlast", AXIS_M_TLAST, 1);
                    check("tid", AXIS_M_TID, 0);
                end
            end
        end else begin
            held = 0;
        end
    end

    task automatic pulse_start(int first, int count, int words, int base, logic [11:0] dest);
        @(posedge CLK);
        #1;
        START = 1;
        CFG_RF_FIRST = 6'(first);
        CFG_RF_COUNT = 7'(count);
        CFG_WORDS = 10'(words);
        CFG_BASE_ADDR = 9'(base);
        CFG_DEST = dest;
        @(posedge CLK);
        #1;
        START = 0;
        CFG_RF_FIRST = 6'($urandom);
        CFG_RF_COUNT = 7'($urandom);
        CFG_WORDS = 10'($urandom);
        CFG_BASE_ADDR = 9'($urandom);
        CFG_DEST = 12'($urandom);
    endtask

    function automatic int load_model(int first, int count, int words, int base, logic [11:0] dest);
        flit_t f;
        int n = 0;
        for (int r = first; r < first + count; r++)
            for (int i = 0; i < words; i++) begin
                f.data = rnd();
                f.user = (75'(1) << (11 + r)) | (75'(3) << 9) | 75'((base + i) % 512);
                f.dest = dest;
                dq.push_back(f.data);
                exp_q.push_back(f);
                n++;
            end
        return n;
    endfunction

    task automatic wait_done(int d0, int limit);
        int k = 0;
        while (done_cnt == d0 && k < limit) begin
            @(negedge CLK);
            k++;
        end
        check("done_seen", done_cnt > d0, 1);
    endtask

    task automatic run_job(int first, int count, int words, int base, logic [11:0] dest, bit restart);
        int d0 = done_cnt, e0 = err_cnt, f0 = flits, n = 0;
        bit bad = first + count > 64;
        busy_seen = 0;
        first_cyc = -1;
        if (!bad) n = load_model(first, count, words, base, dest);
        pulse_start(first, count, words, base, dest);
        if (restart) begin
            repeat (4) @(posedge CLK);
            check("busy_at_restart", BUSY, 1);
            pulse_start(0, 1, 1, 0, 12'habc);
        end
        if (bad) begin
            repeat (4) @(negedge CLK);
            check("err_pulses", err_cnt - e0, 1);
            check("err_no_busy", busy_seen, 0);
            check("err_no_flits", flits - f0, 0);
            check("err_no_done", done_cnt - d0, 0);
        end else begin
            wait_done(d0, 20000);
            repeat (3) @(negedge CLK);
            check("done_once", done_cnt - d0, 1);
            check("flit_count", flits - f0, n);
            check("queue_empty", exp_q.size(), 0);
            check("no_err", err_cnt - e0, 0);
        end
    endtask

    initial begin
        int d0, f0, k, first, count;
        RST_N = 0;
        START = 0;
        CFG_DEST = 0;
        CFG_BASE_ADDR = 0;
        CFG_WORDS = 0;
        CFG_RF_FIRST = 0;
        CFG_RF_COUNT = 0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", {AXIS_M_TVALID, AXIS_M_TLAST, BUSY, DONE, ERR, WDATA_READY,
              |AXIS_M_TDATA, |AXIS_M_TUSER, |AXIS_M_TDEST, |AXIS_M_TID}, 0);
        @(posedge CLK);
        #2;
        RST_N = 1;

        tready_mode = 0;
        wv_full = 1;
        run_job(0, 64, 1, 1, 12'h001, 0);
        check("basic_back_to_back", last_cyc - first_cyc, 63);
        run_job(5, 2, 4, 510, 12'h2a5, 0);
        check("wrap_back_to_back", last_cyc - first_cyc, 7);
        tready_mode = 1;
        run_job(5, 2, 4, 510, 12'h3c1, 0);
        run_job(20, 3, 5, 7, 12'h044, 0);
        tready_mode = 2;
        wv_full = 0;
        for (int j = 0; j < 5; j++) begin
            first = $urandom_range(0, 63);
            count = $urandom_range(1, (64 - first) < 4 ? 64 - first : 4);
            run_job(first, count, $urandom_range(1, 12), $urandom_range(0, 511), 12'($urandom), 0);
        end
        run_job(63, 1, 512, 0, 12'h7ff, 0);
        run_job(60, 8, 4, 0, 12'h111, 0);
        run_job(63, 2, 1, 0, 12'h111, 0);
        run_job(3, 0, 5, 0, 12'h222, 0);
        run_job(3, 2, 0, 0, 12'h333, 0);

        tready_mode = 0;
        wv_full = 1;
        f0 = flits;
        void'(load_model(0, 2, 5, 40, 12'h0f0));
        pulse_start(0, 2, 5, 40, 12'h0f0);
        k = 0;
        while (flits < f0 + 3 && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check("mid_job_progress", flits >= f0 + 3, 1);
        @(posedge CLK);
        #2;
        RST_N = 0;
        dq.delete();
        exp_q.delete();
        d0 = done_cnt;
        @(posedge CLK);
        @(negedge CLK);
        check("midreset_outputs", {AXIS_M_TVALID, AXIS_M_TLAST, BUSY, DONE, ERR, WDATA_READY,
              |AXIS_M_TDATA, |AXIS_M_TUSER, |AXIS_M_TDEST, |AXIS_M_TID}, 0);
        @(posedge CLK);
        #2;
        RST_N = 1;
        repeat (20) @(negedge CLK);
        check("midreset_no_done", done_cnt - d0, 0);
        check("midreset_no_busy", BUSY, 0);
        run_job(1, 2, 3, 100, 12'h155, 0);

        tready_mode = 2;
        run_job(10, 3, 6, 508, 12'h0aa, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1);
    end
endmodule
